note_field_engine: RTL
======================

Name: note_field_engine

Overview:
- Multi-slot successor to the single-note rectangle bounds check.
- Holds up to NUM_NOTES falling notes and scrolls them down once per frame.
- Answers a pipelined per-pixel "inside any note" query for the VGA colour path, and resolves strum hits and misses against a hit window.
- Sits between the song/note sequencer (load side), the PS2/strum input logic and the VGA pixel generator.

Parameters:
- NUM_NOTES, 8, number of note slots (1..16).
- X_W, 10, width of note_x and curr_x.
- Y_W, 12, width of note_y; Y_LIMIT + SCROLL_STEP < 2^Y_W is required.
- CY_W, 9, width of curr_y.
- SIZE_W, 7, width of note_width (note is a square: width x width).
- SCROLL_STEP, 2, pixels added to each valid note_y per frame_tick.
- Y_LIMIT, 480, note retires as missed when its y reaches or exceeds this value.
- HIT_Y_MIN, 400, lowest note_y inside the hit window (inclusive).
- HIT_Y_MAX, 440, highest note_y inside the hit window (inclusive).
- INCLUSIVE, 0, 0 = strict edge compares; 1 = edges count as inside.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears all state.
- load_valid  in  1  request to insert a note.
- load_ready  out  1  at least one slot is free.
- load_x  in  X_W  note left edge.
- load_y  in  Y_W  note top edge.
- load_width  in  SIZE_W  note size.
- frame_tick  in  1  one-cycle pulse per frame; scroll strobe.
- strum_valid  in  1  one-cycle strum pulse.
- strum_x  in  X_W  lane x to match against note_x.
- pixel_valid  in  1  curr_x/curr_y are a visible pixel.
- curr_x  in  X_W  pixel x.
- curr_y  in  CY_W  pixel y.
- in_note  out  1  pixel is inside some valid note (2-cycle latency).
- note_idx  out  4  lowest-index slot containing the pixel (0 when in_note=0).
- hit  out  1  one-cycle pulse: strum matched a note.
- strum_miss  out  1  one-cycle pulse: strum matched nothing.
- note_missed  out  1  one-cycle pulse: at least one note retired off-screen on this tick.
- active_count  out  5  number of valid slots.

Behaviour:
- Reset: all slots invalid; in_note=0, note_idx=0, hit=0, strum_miss=0, note_missed=0, active_count=0; load_ready=1.
- Slot state per slot: valid, x[X_W], y[Y_W], w[SIZE_W].
- Load:
  - A transfer occurs when load_valid & load_ready.
  - The note is written into the lowest-index free slot, with the free mask taken from registered state. Visible the next cycle.
  - load_ready = ~&valid (combinational from registers). A slot freed in the same cycle is not reusable until the next cycle.
- Scroll: on frame_tick, every valid slot gets y <= y + SCROLL_STEP.
  - If y + SCROLL_STEP >= Y_LIMIT, the slot is invalidated instead and note_missed pulses the next cycle (one pulse even if several retire).
- Strum:
  - Candidates are valid slots with x == strum_x and HIT_Y_MIN <= y <= HIT_Y_MAX, using pre-tick registered y.
  - The lowest-index candidate is invalidated and hit pulses the next cycle.
  - If there is no candidate, strum_miss pulses the next cycle.
- Simultaneous events in one cycle:
  - Strum is evaluated on pre-scroll positions.
  - A slot that is both strummed and would retire counts as a hit only; no note_missed for that slot.
  - Load may coincide with tick or strum. A loaded note is not scrolled in its load cycle.
- Pixel path (2-stage pipeline):
  - Stage 1 registers, per slot, inside_i = valid & pixel_valid & the four edge compares. Uses slot state at the input cycle.
  - Strict edges: curr_x > x, curr_x < x+w, curr_y > y, curr_y < y+w. INCLUSIVE=1 uses >= and <=.
  - Sums x+w and y+w are computed one bit wider than the operand (no wrap). curr_y is zero-extended to Y_W.
  - Stage 2 registers in_note = |inside and note_idx = priority-encoded lowest set index.
  - Throughput is 1 pixel per cycle. pixel_valid=0 forces in_note=0 two cycles later.
- active_count is registered and equals popcount(valid), updated the same edge as slot changes.
- Reset mid-operation clears the pipeline registers too; no stale in_note after reset.

Test Plan:
- Load x=100, y=50, w=20; pixel (110,60) -> in_note=1, note_idx=0 exactly 2 cycles later. Pixel (100,60) -> 0 with INCLUSIVE=0 and 1 with INCLUSIVE=1.
- Load 8 notes -> load_ready=0 and active_count=8; a 9th load_valid is ignored. Strum one of them into the window -> load_ready=1 the next cycle.
- Note y=476, frame_tick (step 2) -> y=478, no miss. Second tick -> slot invalid, note_missed pulses once, active_count decrements.
- Two notes with x=200 at y=410 (slot 1) and y=420 (slot 3); strum_x=200 -> slot 1 cleared, hit=1. Strum again -> slot 3 cleared. Third strum -> strum_miss=1.
- Note at y=440 with frame_tick and strum in the same cycle -> hit=1 (pre-scroll y in window), y not updated, no note_missed.
- Overlapping notes in slots 2 and 5 covering pixel (300,200) -> note_idx=2. Assert reset with pixels in flight -> in_note=0 on every cycle after reset.

Source files
------------

// File: rtl/note_field_engine.sv
// note_field_engine
// Keeps a small pool of falling square notes for the rhythm game. The song
// sequencer drops notes in through the load interface, every frame_tick moves
// them down the screen, strums knock out the lowest-index note sitting in the
// hit window, and the VGA path asks each pixel whether it lands in a note.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   load_valid/ready     insert handshake; load_x/load_y/load_width give the note
//   frame_tick           once-per-frame scroll strobe
//   strum_valid/strum_x  strum pulse and the lane x it targets
//   pixel_valid/curr_x/curr_y  pixel query from the VGA generator
//   in_note/note_idx     pixel query answer, two cycles after the query
//   hit/strum_miss       one-cycle strum result pulses
//   note_missed          one-cycle pulse when any note scrolled off the bottom
//   active_count         number of occupied slots
module note_field_engine #(
   parameter int NUM_NOTES   = 8,
   parameter int X_W         = 10,
   parameter int Y_W         = 12,
   parameter int CY_W        = 9,
   parameter int SIZE_W      = 7,
   parameter int SCROLL_STEP = 2,
   parameter int Y_LIMIT     = 480,
   parameter int HIT_Y_MIN   = 400,
   parameter int HIT_Y_MAX   = 440,
   parameter int INCLUSIVE   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [X_W-1:0]    load_x,
   input  logic [Y_W-1:0]    load_y,
   input  logic [SIZE_W-1:0] load_width,
   input  logic              frame_tick,
   input  logic              strum_valid,
   input  logic [X_W-1:0]    strum_x,
   input  logic              pixel_valid,
   input  logic [X_W-1:0]    curr_x,
   input  logic [CY_W-1:0]   curr_y,
   output logic              in_note,
   output logic [3:0]        note_idx,
   output logic              hit,
   output logic              strum_miss,
   output logic              note_missed,
   output logic [4:0]        active_count
);

   localparam logic [Y_W:0]   LIMIT = (Y_W+1)'(Y_LIMIT);
   localparam logic [Y_W:0]   STEP  = (Y_W+1)'(SCROLL_STEP);
   localparam logic [Y_W-1:0] H_MIN = Y_W'(HIT_Y_MIN);
   localparam logic [Y_W-1:0] H_MAX = Y_W'(HIT_Y_MAX);

   logic [NUM_NOTES-1:0] valid_q, valid_d;
   logic [X_W-1:0]       x_q [NUM_NOTES];
   logic [X_W-1:0]       x_d [NUM_NOTES];
   logic [Y_W-1:0]       y_q [NUM_NOTES];
   logic [Y_W-1:0]       y_d [NUM_NOTES];
   logic [SIZE_W-1:0]    w_q [NUM_NOTES];
   logic [SIZE_W-1:0]    w_d [NUM_NOTES];
   logic [Y_W:0]         y_scrolled [NUM_NOTES];
   logic [NUM_NOTES-1:0] retire;
   logic [NUM_NOTES-1:0] inside_d, inside_q;
   logic                 any_cand;
   logic [3:0]           cand_idx;
   logic [3:0]           free_idx;
   logic                 load_fire;
   logic [4:0]           count_d;
   logic                 any_inside;
   logic [3:0]           inside_idx;

   assign load_ready = ~&valid_q;
   assign load_fire  = load_valid & load_ready;

   // Find the lowest-index strum candidate and the lowest-index free slot.
   // Walking downward lets the lowest index overwrite the others.
   // Both use the registered state only, so a slot freed this cycle cannot
   // be reused until the next one.
   always_comb begin
      any_cand = 1'b0;
      cand_idx = '0;
      free_idx = '0;
      for (int i = NUM_NOTES - 1; i >= 0; i--) begin
         if (valid_q[i] && (x_q[i] == strum_x) && (y_q[i] >= H_MIN) && (y_q[i] <= H_MAX)) begin
            any_cand = 1'b1;
            cand_idx = 4'(i);
         end
         if (!valid_q[i]) begin
            free_idx = 4'(i);
         end
      end
   end

   // Next slot state. A strum takes priority over the scroll, so a note that
   // is hit on a tick where it would also fall off is treated as a hit only.
   // A load always targets a free slot, so it never collides with the
   // strum or scroll updates and is not scrolled in its own load cycle.
   always_comb begin
      valid_d = valid_q;
      x_d     = x_q;
      y_d     = y_q;
      w_d     = w_q;
      retire  = '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         y_scrolled[i] = {1'b0, y_q[i]} + STEP;
         if (strum_valid && any_cand && (cand_idx == 4'(i))) begin
            valid_d[i] = 1'b0;
         end else if (frame_tick && valid_q[i]) begin
            if (y_scrolled[i] >= LIMIT) begin
               valid_d[i] = 1'b0;
               retire[i]  = 1'b1;
            end else begin
               y_d[i] = y_scrolled[i][Y_W-1:0];
            end
         end
         if (load_fire && (free_idx == 4'(i))) begin
            valid_d[i] = 1'b1;
            x_d[i]     = load_x;
            y_d[i]     = load_y;
            w_d[i]     = load_width;
         end
      end
   end

   // Occupancy count tracks the next valid mask so it moves on the same edge.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         count_d = count_d + 5'(valid_d[i]);
      end
   end

   // First pixel stage: per-slot rectangle test. The right and bottom edges
   // are computed one bit wider so a note near the maximum coordinate
   // cannot wrap around and swallow pixels at the top or left.
   always_comb begin
      inside_d = '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         logic [X_W:0] cx, x_lo, x_hi;
         logic [Y_W:0] cy, y_lo, y_hi;
         logic         x_ok, y_ok;
         cx   = {1'b0, curr_x};
         x_lo = {1'b0, x_q[i]};
         x_hi = {1'b0, x_q[i]} + (X_W+1)'(w_q[i]);
         cy   = (Y_W+1)'(curr_y);
         y_lo = {1'b0, y_q[i]};
         y_hi = {1'b0, y_q[i]} + (Y_W+1)'(w_q[i]);
         if (INCLUSIVE != 0) begin
            x_ok = (cx >= x_lo) && (cx <= x_hi);
            y_ok = (cy >= y_lo) && (cy <= y_hi);
         end else begin
            x_ok = (cx > x_lo) && (cx < x_hi);
            y_ok = (cy > y_lo) && (cy < y_hi);
         end
         inside_d[i] = valid_q[i] & pixel_valid & x_ok & y_ok;
      end
   end

   // Second pixel stage: reduce the per-slot flags to a hit flag plus the
   // lowest matching slot index, which is 0 when nothing matched.
   always_comb begin
      any_inside = |inside_q;
      inside_idx = '0;
      for (int i = NUM_NOTES - 1; i >= 0; i--) begin
         if (inside_q[i]) begin
            inside_idx = 4'(i);
         end
      end
   end

   // All registers, including the pixel pipeline, clear on reset so no stale
   // in_note can appear once reset is released.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q      <= '0;
         inside_q     <= '0;
         in_note      <= 1'b0;
         note_idx     <= '0;
         hit          <= 1'b0;
         strum_miss   <= 1'b0;
         note_missed  <= 1'b0;
         active_count <= '0;
         for (int i = 0; i < NUM_NOTES; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
            w_q[i] <= '0;
         end
      end else begin
         valid_q      <= valid_d;
         x_q          <= x_d;
         y_q          <= y_d;
         w_q          <= w_d;
         inside_q     <= inside_d;
         in_note      <= any_inside;
         note_idx     <= inside_idx;
         hit          <= strum_valid & any_cand;
         strum_miss   <= strum_valid & ~any_cand;
         note_missed  <= |retire;
         active_count <= count_d;
      end
   end

endmodule
